// File: rtl/sram_port0_ctrl_if.sv
// Request/response channel between the core datapath and the SRAM port-0 controller.
interface sram_port0_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  wr_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, wr_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, wr_done
  );
endinterface

// File: rtl/sram_port0_ctrl.sv
// Front-end for the RW port of the 32x512 OpenRAM macro: one request in flight,
// registered active-low macro controls, read data returned with backpressure.
module sram_port0_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_port0_ctrl_if.slave      bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RSP, WR} state_t;

  state_t                state_q, state_d;
  logic                  csb_d, web_d, rsp_valid_d, wr_done_d;
  logic [NUM_WMASKS-1:0] wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d, rdata_d;
  logic                  ready;
  logic                  rsp_valid_q, wr_done_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    ready = (state_q == IDLE) && !rst;
  end

  always_comb begin
    state_d     = state_q;
    csb_d       = sram_csb0;
    web_d       = sram_web0;
    wmask_d     = sram_wmask0;
    addr_d      = sram_addr0;
    din_d       = sram_din0;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    wr_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && ready) begin
          if (bus.req_we) begin
            // A write with no enabled lanes never touches the macro.
            if (bus.req_wmask != '0) begin
              csb_d   = 1'b0;
              web_d   = 1'b0;
              wmask_d = bus.req_wmask;
              din_d   = bus.req_wdata;
              addr_d  = bus.req_addr;
              state_d = WR;
            end else begin
              wr_done_d = 1'b1;
            end
          end else begin
            csb_d   = 1'b0;
            web_d   = 1'b1;
            wmask_d = '0;
            addr_d  = bus.req_addr;
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        csb_d   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d     = sram_dout0;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      WR: begin
        csb_d     = 1'b1;
        web_d     = 1'b1;
        wmask_d   = '0;
        wr_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sram_csb0   <= csb_d;
      sram_web0   <= web_d;
      sram_wmask0 <= wmask_d;
      sram_addr0  <= addr_d;
      sram_din0   <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.wr_done   = wr_done_q;

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Directed bench for sram_port0_ctrl with a behavioural model of the macro's port 0.
module tb_sram_port0_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;
  logic [31:0] mem [512];
  int checks = 0;
  int failures = 0;

  sram_port0_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_WMASKS(4)) bus ();

  sram_port0_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_WMASKS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // Macro port 0: controls sampled on the rising edge, read data valid the cycle after.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!sram_web0 && sram_csb0) begin
        failures++; $display("FAIL web_without_csb: web0=%b csb0=%b want web0=1 when csb0=1", sram_web0, sram_csb0);
      end
    end
  end

  task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] data, input logic [3:0] mask);
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = data; bus.req_wmask = mask; bus.req_valid = 1'b1;
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] mask);
    issue(1'b1, addr, data, mask);
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  // lat = rising edges from acceptance to rsp_valid, -1 if it never arrives.
  task automatic do_read(input logic [8:0] addr, output logic [31:0] data, output int lat);
    lat = -1; data = 'x;
    issue(1'b0, addr, '0, '0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin data = bus.rsp_rdata; lat = i; break; end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_ready = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({sram_csb0, sram_web0} !== 2'b11) begin failures++; $display("FAIL rst_ctl: csb0/web0=%b want 11", {sram_csb0, sram_web0}); end
    checks++; if ({sram_wmask0, sram_addr0, sram_din0} !== '0) begin failures++; $display("FAIL rst_bus: wmask=%h addr=%h din=%h want 0", sram_wmask0, sram_addr0, sram_din0); end
    checks++; if ({bus.rsp_valid, bus.wr_done, bus.req_ready} !== 3'b000) begin failures++; $display("FAIL rst_hs: rsp_valid/wr_done/req_ready=%b want 000", {bus.rsp_valid, bus.wr_done, bus.req_ready}); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata); end
    rst = 1'b0; #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    // Reset landing in RD_WAIT.
    @(negedge clk); issue(1'b0, 9'h010, '0, '0);
    @(negedge clk); bus.req_valid = 1'b0;
    checks++; if (sram_csb0 !== 1'b0) begin failures++; $display("FAIL midrd_csb: got %b want 0", sram_csb0); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if ({sram_csb0, bus.rsp_valid, bus.req_ready} !== 3'b100) begin failures++; $display("FAIL midrd_rst: csb0/rsp_valid/req_ready=%b want 100", {sram_csb0, bus.rsp_valid, bus.req_ready}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if ({sram_csb0, bus.rsp_valid, bus.req_ready} !== 3'b101) begin failures++; $display("FAIL midrd_after: csb0/rsp_valid/req_ready=%b want 101", {sram_csb0, bus.rsp_valid, bus.req_ready}); end
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrd_norsp: rsp_valid cycles=%0d want 0", seen); end
  endtask

  task automatic test_write_read();
    issue(1'b1, 9'h1A5, 32'hDEADBEEF, 4'hF);
    @(negedge clk); bus.req_valid = 1'b0;
    checks++; if ({sram_csb0, sram_web0, sram_wmask0} !== 6'b00_1111) begin failures++; $display("FAIL wr_ctl: csb0/web0/wmask=%b want 001111", {sram_csb0, sram_web0, sram_wmask0}); end
    checks++; if ({sram_addr0, sram_din0} !== {9'h1A5, 32'hDEADBEEF}) begin failures++; $display("FAIL wr_bus: addr=%h din=%h want 1a5 deadbeef", sram_addr0, sram_din0); end
    checks++; if ({bus.req_ready, bus.wr_done} !== 2'b00) begin failures++; $display("FAIL wr_hs1: req_ready/wr_done=%b want 00", {bus.req_ready, bus.wr_done}); end
    @(negedge clk);
    checks++; if ({sram_csb0, sram_web0, sram_wmask0, bus.wr_done, bus.req_ready} !== 8'b11_0000_11) begin failures++; $display("FAIL wr_done: csb0/web0/wmask/wr_done/ready=%b want 11000011", {sram_csb0, sram_web0, sram_wmask0, bus.wr_done, bus.req_ready}); end
    checks++; if ({sram_addr0, sram_din0} !== {9'h1A5, 32'hDEADBEEF}) begin failures++; $display("FAIL wr_hold: addr=%h din=%h want 1a5 deadbeef", sram_addr0, sram_din0); end
    @(negedge clk);
    checks++; if (bus.wr_done !== 1'b0) begin failures++; $display("FAIL wr_pulse: wr_done=%b want 0", bus.wr_done); end
    issue(1'b0, 9'h1A5, '0, '0);
    @(negedge clk); bus.req_valid = 1'b0;
    checks++; if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0} !== {2'b01, 4'h0, 9'h1A5}) begin failures++; $display("FAIL rd_ctl: csb0=%b web0=%b wmask=%h addr=%h want 0 1 0 1a5", sram_csb0, sram_web0, sram_wmask0, sram_addr0); end
    @(negedge clk);
    checks++; if ({sram_csb0, bus.rsp_valid} !== 2'b10) begin failures++; $display("FAIL rd_wait: csb0/rsp_valid=%b want 10", {sram_csb0, bus.rsp_valid}); end
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL rd_rsp: valid=%b rdata=%h want 1 deadbeef", bus.rsp_valid, bus.rsp_rdata); end
    bus.rsp_ready = 1'b1;
    @(negedge clk); bus.rsp_ready = 1'b0;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin failures++; $display("FAIL rd_hs: rsp_valid/req_ready=%b want 01", {bus.rsp_valid, bus.req_ready}); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] d; int lat;
    do_write(9'h1A5, 32'h11223344, 4'b0101);
    do_read(9'h1A5, d, lat);
    checks++; if (d !== 32'hDE22BE44 || lat != 2) begin failures++; $display("FAIL mask_rd: rdata=%h lat=%0d want de22be44 2", d, lat); end
  endtask

  task automatic test_zero_mask();
    logic [31:0] d; int lat;
    issue(1'b1, 9'h1A5, 32'hFFFFFFFF, 4'h0);
    @(negedge clk); bus.req_valid = 1'b0;
    checks++; if ({bus.wr_done, sram_csb0, sram_web0, bus.req_ready} !== 4'b1111) begin failures++; $display("FAIL zm_done: wr_done/csb0/web0/ready=%b want 1111", {bus.wr_done, sram_csb0, sram_web0, bus.req_ready}); end
    @(negedge clk);
    checks++; if ({bus.wr_done, sram_csb0} !== 2'b01) begin failures++; $display("FAIL zm_after: wr_done/csb0=%b want 01", {bus.wr_done, sram_csb0}); end
    do_read(9'h1A5, d, lat);
    checks++; if (d !== 32'hDE22BE44) begin failures++; $display("FAIL zm_rd: rdata=%h want de22be44", d); end
  endtask

  task automatic test_backpressure();
    int lat = -1;
    issue(1'b0, 9'h1A5, '0, '0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin lat = i; break; end
    end
    checks++; if (lat != 2) begin failures++; $display("FAIL bp_lat: latency=%0d want 2", lat); end
    issue(1'b1, 9'h055, 32'h0BADF00D, 4'hF);
    repeat (5) begin
      @(negedge clk);
      checks++; if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready, sram_csb0} !== {1'b1, 32'hDE22BE44, 1'b0, 1'b1}) begin
        failures++; $display("FAIL bp_hold: valid=%b rdata=%h ready=%b csb0=%b want 1 de22be44 0 1", bus.rsp_valid, bus.rsp_rdata, bus.req_ready, sram_csb0);
      end
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk); bus.rsp_ready = 1'b0;
    checks++; if ({bus.rsp_valid, bus.req_ready, sram_csb0} !== 3'b011) begin failures++; $display("FAIL bp_release: valid/ready/csb0=%b want 011", {bus.rsp_valid, bus.req_ready, sram_csb0}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  csb_trace;
    logic [31:0] got [2];
    int nrsp = 0;
    int accesses = 0;
    issue(1'b1, 9'h000, 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      csb_trace[i] = sram_csb0;
      if (i == 0) issue(1'b1, 9'h1FF, 32'h5A5A5A5A, 4'hF);
      if (i == 2) bus.req_valid = 1'b0;
    end
    checks++; if (csb_trace !== 4'b1010) begin failures++; $display("FAIL b2b_wr: csb0 trace(neg3..0)=%b want 1010", csb_trace); end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    issue(1'b0, 9'h000, '0, '0);
    for (int i = 0; i < 20 && nrsp < 2; i++) begin
      @(negedge clk);
      if (!sram_csb0) accesses++;
      if (i == 0) bus.req_addr = 9'h1FF;
      if (bus.rsp_valid) begin
        got[nrsp] = bus.rsp_rdata; nrsp++;
        if (nrsp == 2) bus.req_valid = 1'b0;
      end
    end
    @(negedge clk); bus.rsp_ready = 1'b0;
    checks++; if (nrsp != 2 || accesses != 2) begin failures++; $display("FAIL b2b_rd_count: responses=%0d accesses=%0d want 2 2", nrsp, accesses); end
    checks++; if (got[0] !== 32'hA5A5A5A5 || got[1] !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_rd_data: got %h %h want a5a5a5a5 5a5a5a5a", got[0], got[1]); end
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin failures++; $display("FAIL b2b_idle: rsp_valid/req_ready=%b want 01", {bus.rsp_valid, bus.req_ready}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_zero_mask();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end
endmodule

// File: doc/sram_port0_ctrl.md
Name: sram_port0_ctrl

Overview:
Request/response front-end that drives the RW port (port 0) of the 32x512 OpenRAM SRAM macro (sky130_sram_2kbyte_1rw1r_32x512_8).
- Accepts single-word read/write requests on a valid/ready interface and converts them into registered, active-low macro controls.
- Captures macro read data and returns it on a valid/ready response channel with backpressure.
- Sits between the core datapath (upstream) and the SRAM macro (downstream); macro clk0 is tied to clk.

Parameters:
- DATA_WIDTH, 32, word width; must equal macro data width.
- ADDR_WIDTH, 9, word address width (512 words).
- NUM_WMASKS, 4, byte-lane count = DATA_WIDTH/8.

Ports:
- clk  in  1  single clock; also drives macro clk0.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  NUM_WMASKS  byte enables (bit i covers data[8i+7:8i]).
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_WIDTH  read data.
- wr_done  out  1  one-cycle pulse when a write has been presented to the macro.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  NUM_WMASKS  macro write mask.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset values (async on rst high): state IDLE, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, rsp_valid=0, rsp_rdata=0, wr_done=0.
- All sram_* outputs are registered. The macro samples them on the following clk edge.
- req_ready = (state==IDLE) && !rst; it is combinational from state. At most one request is in flight.
- States: IDLE, RD_ISSUE, RD_WAIT, RSP, WR.
- Read, accepted at edge A:
  - sram_csb0<=0, sram_web0<=1, sram_wmask0<=0, sram_addr0<=req_addr; state->RD_ISSUE.
  - Edge A+1: macro samples; sram_csb0<=1; state->RD_WAIT.
  - Edge A+2: rsp_rdata<=sram_dout0, rsp_valid<=1; state->RSP.
  - Latency from acceptance to rsp_valid is 2 cycles.
- RSP: rsp_valid and rsp_rdata are held stable until rsp_ready is sampled high. On that edge rsp_valid<=0 and state->IDLE. The next request is accepted no earlier than the following edge.
- Write with req_wmask!=0, accepted at edge A:
  - sram_csb0<=0, sram_web0<=0, sram_wmask0<=req_wmask, sram_din0<=req_wdata, sram_addr0<=req_addr; state->WR.
  - Edge A+1: sram_csb0<=1, sram_web0<=1, sram_wmask0<=0, wr_done<=1 (one cycle); state->IDLE.
  - Write throughput is 1 per 2 cycles.
- Write with req_wmask==0: accepted as a no-op. State stays IDLE, sram_csb0 stays 1, wr_done<=1 for one cycle.
- sram_csb0 is low for exactly one cycle per macro access. sram_web0 is low only while sram_csb0 is low.
- sram_din0 and sram_addr0 retain their last values when idle; no toggling between accesses.
- rsp_ready is ignored outside RSP. req_* inputs are ignored whenever req_ready=0.
- Reset mid-operation: state and all outputs return to reset values immediately. Any pending response is discarded. A write already sampled by the macro is not undone.
- Read-after-write to the same address returns the new data: the write completes at A+1 before the read can be issued.

Test Plan:
- Reset: assert rst mid-read (state RD_WAIT) -> sram_csb0=1, rsp_valid=0, req_ready=1 one cycle after rst deasserts; no rsp_valid follows.
- Full write then read: write addr 0x1A5, data 0xDEADBEEF, mask 4'hF -> sram_csb0/sram_web0 low for 1 cycle; wr_done pulse. Then read 0x1A5 -> rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF.
- Byte mask: over 0xDEADBEEF at 0x1A5, write 0x11223344 with mask 4'b0101 -> subsequent read returns 0xDE22BE44.
- Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, no macro access. Raise rsp_ready -> rsp_valid drops next edge, req_ready=1.
- Zero-mask write: req_we=1, mask 0 -> accepted, wr_done pulse, sram_csb0 stays 1, memory unchanged (readback confirms).
- Address boundaries and back-to-back streaming: write/read addr 0x000 and 0x1FF with req_valid held high continuously -> one access per 2 cycles (write) / per response handshake (read), correct data at both ends.
